// File: rtl/sponge_pkg.sv
// sponge_pkg: shared FSM encoding, Cyclist domain constants and byte-lane helper.
package sponge_pkg;
  typedef enum logic [3:0] {
    IDLE, ABSORB, ABS_UP, ABS_WAIT, FINAL, SQZ_UP, SQZ_WAIT, EXTRACT, SQZ_DOWN, DONE
  } state_t;
  localparam logic [7:0] PAD      = 8'h01;
  localparam logic [7:0] CD_FIRST = 8'h03;
  localparam logic [7:0] CD_NEXT  = 8'h00;
  localparam logic [7:0] CU_SQZ   = 8'h40;
  localparam logic [7:0] CU_NONE  = 8'h00;
  function automatic int lane(input int i);
    return 8 * i;
  endfunction
endpackage

// File: rtl/sponge_hash_ctrl.sv
// sponge_hash_ctrl: streaming Cyclist hash controller driving an external permutation.
module sponge_hash_ctrl
  import sponge_pkg::*;
#(
  parameter int RATE_BYTES  = 16,
  parameter int STATE_BYTES = 48,
  parameter int HASH_BYTES  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               msg_data,
  input  logic                     msg_valid,
  input  logic                     msg_last,
  input  logic                     msg_null,
  output logic                     msg_ready,
  output logic                     perm_start,
  output logic [8*STATE_BYTES-1:0] perm_state_out,
  input  logic                     perm_done,
  input  logic [8*STATE_BYTES-1:0] perm_state_in,
  output logic [7:0]               hash_data,
  output logic                     hash_valid,
  output logic                     hash_last,
  input  logic                     hash_ready,
  output logic                     busy
);
  localparam int SW = 8 * STATE_BYTES;
  localparam int IW = $clog2(RATE_BYTES + 1);
  localparam int OW = $clog2(HASH_BYTES + 1);
  state_t state, state_n;
  logic [SW-1:0] s;
  logic [IW-1:0] idx, oidx;
  logic [OW-1:0] outcnt;
  logic [7:0] cd, cu;
  logic take, rate_full, blk_end, out_end;
  function automatic logic [SW-1:0] lane_mask(input int i, input logic [7:0] v);
    return SW'(v) << lane(i);
  endfunction
  assign perm_state_out = s;
  assign take      = msg_valid && msg_ready && !msg_null;
  assign rate_full = idx + IW'(1) == IW'(RATE_BYTES);
  assign blk_end   = oidx == IW'(RATE_BYTES - 1);
  assign out_end   = outcnt == OW'(HASH_BYTES - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, ABSORB: if (msg_valid && msg_ready)
        state_n = msg_last ? FINAL : !take ? state : rate_full ? ABS_UP : ABSORB;
      ABS_UP:   state_n = ABS_WAIT;
      ABS_WAIT: state_n = perm_done ? ABSORB : ABS_WAIT;
      FINAL:    state_n = SQZ_UP;
      SQZ_UP:   state_n = SQZ_WAIT;
      SQZ_WAIT: state_n = perm_done ? EXTRACT : SQZ_WAIT;
      EXTRACT:  state_n = !hash_ready ? EXTRACT : out_end ? DONE : blk_end ? SQZ_DOWN : EXTRACT;
      SQZ_DOWN: state_n = SQZ_UP;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    msg_ready = resetn && (state == IDLE || (state == ABSORB && idx != IW'(RATE_BYTES)));
    busy      = state != IDLE && state != DONE;
  end
  // perm_start is issued the cycle after the pad/domain XOR so S is already final when it rises
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s          <= '0;
      idx        <= '0;
      oidx       <= '0;
      outcnt     <= '0;
      cd         <= CD_FIRST;
      cu         <= CU_SQZ;
      perm_start <= 1'b0;
      hash_valid <= 1'b0;
      hash_data  <= '0;
      hash_last  <= 1'b0;
    end else begin
      perm_start <= state == ABS_UP || state == SQZ_UP;
      case (state)
        IDLE, ABSORB: if (take) begin
          s[lane(int'(idx)) +: 8] <= s[lane(int'(idx)) +: 8] ^ msg_data;
          idx <= idx + IW'(1);
        end
        ABS_UP: begin
          s  <= s ^ lane_mask(int'(idx), PAD) ^ lane_mask(STATE_BYTES - 1, cd);
          cd <= CD_NEXT;
        end
        ABS_WAIT: if (perm_done) begin
          s   <= perm_state_in;
          idx <= '0;
        end
        FINAL: s <= s ^ lane_mask(int'(idx), PAD) ^ lane_mask(STATE_BYTES - 1, cd);
        SQZ_UP: begin
          s  <= s ^ lane_mask(STATE_BYTES - 1, cu);
          cu <= CU_NONE;
        end
        SQZ_WAIT: if (perm_done) begin
          s          <= perm_state_in;
          oidx       <= '0;
          hash_valid <= 1'b1;
          hash_data  <= perm_state_in[7:0];
          hash_last  <= out_end;
        end
        EXTRACT: if (hash_ready) begin
          oidx       <= oidx + IW'(1);
          outcnt     <= outcnt + OW'(1);
          hash_valid <= !(out_end || blk_end);
          hash_last  <= !(out_end || blk_end) && outcnt + OW'(1) == OW'(HASH_BYTES - 1);
          hash_data  <= s[lane(int'(oidx) + 1) +: 8];
        end
        SQZ_DOWN: s <= s ^ lane_mask(0, PAD) ^ lane_mask(STATE_BYTES - 1, CD_NEXT);
        DONE: begin
          s      <= '0;
          idx    <= '0;
          oidx   <= '0;
          outcnt <= '0;
          cd     <= CD_FIRST;
          cu     <= CU_SQZ;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sponge_hash_ctrl.sv
// tb_sponge_hash_ctrl: directed vectors with an identity permutation stub and a digest scoreboard.
module tb_sponge_hash_ctrl;
  localparam int R = 16, ST = 48, H = 32;
  logic clk = 0, resetn = 0;
  logic [7:0] msg_data = 0;
  logic msg_valid = 0, msg_last = 0, msg_null = 0, msg_ready;
  logic perm_start, perm_done = 0;
  logic [8*ST-1:0] perm_state_out, perm_state_in = '0;
  logic [7:0] hash_data;
  logic hash_valid, hash_last, hash_ready = 1, busy;
  int checks = 0, errors = 0, pstarts = 0, pwait = 0, p0;
  bit rmode = 0, stalled = 0;
  logic [8:0] saved, e;
  logic [8:0] q[$];
  logic [7:0] msg[0:31];
  logic [7:0] ex[0:31];

  sponge_hash_ctrl #(.RATE_BYTES(R), .STATE_BYTES(ST), .HASH_BYTES(H)) dut (
    .clk(clk), .resetn(resetn), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_null(msg_null), .msg_ready(msg_ready),
    .perm_start(perm_start), .perm_state_out(perm_state_out), .perm_done(perm_done),
    .perm_state_in(perm_state_in), .hash_data(hash_data), .hash_valid(hash_valid),
    .hash_last(hash_last), .hash_ready(hash_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exv);
    end
  endtask

  // identity permutation, done pulse three cycles after start; not reset on purpose
  always @(posedge clk) begin
    perm_done <= 1'b0;
    if (perm_start) begin
      perm_state_in <= perm_state_out;
      pwait <= 3;
      pstarts <= pstarts + 1;
    end else if (pwait > 0) begin
      pwait <= pwait - 1;
      if (pwait == 1) perm_done <= 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    hash_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!resetn) stalled = 0;
    else begin
      if (stalled) begin
        chk("stall_valid", hash_valid, 1);
        chk("stall_hold", {hash_last, hash_data}, saved);
      end
      if (hash_valid && hash_ready) begin
        if (q.size() == 0) chk("extra_digest_byte", {hash_last, hash_data}, 9'h1ff);
        else begin
          e = q.pop_front();
          chk("digest_byte", {hash_last, hash_data}, e);
        end
      end
      stalled = hash_valid && !hash_ready;
      saved = {hash_last, hash_data};
    end
  end

  task automatic clear_ex();
    for (int i = 0; i < H; i++) ex[i] = 8'h00;
  endtask

  task automatic push_exp();
    for (int i = 0; i < H; i++) q.push_back({i == H - 1, ex[i]});
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic nl, input int i);
    int w = 0;
    msg_data = d; msg_valid = 1; msg_last = l; msg_null = nl;
    forever begin
      @(negedge clk);
      if (i > 0 && i % R == 0 && w < 2) chk("ready_low_during_perm", msg_ready, 0);
      if (msg_ready) break;
      w++;
      if (w > 200) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit last);
    @(posedge clk);
    #1;
    if (n == 0) beat(8'h00, 1, 1, 0);
    for (int i = 0; i < n; i++) beat(msg[i], last && i == n - 1, 0, i);
    msg_valid = 0; msg_last = 0; msg_null = 0;
  endtask

  task automatic wait_idle(input string nm, input int np);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) break;
    end
    chk({nm, "_complete"}, {31'd0, !busy && q.size() == 0}, 1);
    chk({nm, "_perm_starts"}, pstarts - p0, np);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hash_valid", hash_valid, 0);
    chk("rst_perm_start", perm_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state_zero", {31'd0, perm_state_out == '0}, 1);
    resetn = 1;
    @(negedge clk);
    chk("idle_ready", msg_ready, 1);

    clear_ex(); ex[0] = 8'h01;
    p0 = pstarts; push_exp(); send(0, 1); wait_idle("empty", 2);

    clear_ex();
    msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
    ex[0] = 8'hAA; ex[1] = 8'hBB; ex[2] = 8'hCC; ex[3] = 8'h01;
    ex[16] = 8'hAB; ex[17] = 8'hBB; ex[18] = 8'hCC; ex[19] = 8'h01;
    p0 = pstarts; push_exp(); send(3, 1); wait_idle("abc", 2);

    clear_ex();
    for (int i = 0; i < 16; i++) begin msg[i] = 8'(i); ex[i] = 8'(i); ex[16+i] = 8'(i); end
    ex[16] = 8'h01;
    p0 = pstarts; push_exp(); send(16, 1); wait_idle("full_block", 2);

    clear_ex();
    for (int i = 0; i < 17; i++) msg[i] = 8'(i);
    for (int i = 0; i < 16; i++) begin ex[i] = 8'(i); ex[16+i] = 8'(i); end
    ex[0] = 8'h10; ex[1] = 8'h00; ex[16] = 8'h11; ex[17] = 8'h00;
    p0 = pstarts; push_exp(); send(17, 1); wait_idle("seventeen", 3);

    clear_ex();
    msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
    ex[0] = 8'hAA; ex[1] = 8'hBB; ex[2] = 8'hCC; ex[3] = 8'h01;
    ex[16] = 8'hAB; ex[17] = 8'hBB; ex[18] = 8'hCC; ex[19] = 8'h01;
    rmode = 1;
    p0 = pstarts; push_exp(); send(3, 1); wait_idle("stalled_sink", 2);
    rmode = 0;

    for (int i = 0; i < 16; i++) msg[i] = 8'(i);
    send(16, 0);
    repeat (2) begin @(posedge clk); #1; end
    resetn = 0;
    #1;
    chk("midrst_hash_valid", hash_valid, 0);
    chk("midrst_perm_start", perm_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", msg_ready, 0);
    chk("midrst_state_zero", {31'd0, perm_state_out == '0}, 1);
    @(negedge clk);
    resetn = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", msg_ready, 1);
    clear_ex(); ex[0] = 8'h01;
    p0 = pstarts; push_exp(); send(0, 1); wait_idle("post_rst_empty", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
